// File: rtl/arc4_pkg.sv
// Shared types and widths for the ARC4 decrypt sequencer and its S-memory port mux.
package arc4_pkg;

  localparam int unsigned S_AW  = 8;
  localparam int unsigned S_DW  = 8;
  localparam int unsigned KEY_W = 24;
  localparam int unsigned PH_W  = 2;

  typedef enum logic [3:0] {
    S_RST,
    IDLE,
    ST_INIT,
    WT_INIT,
    ST_KSA,
    WT_KSA,
    ST_PRGA,
    WT_PRGA,
    ERR
  } seq_state_t;

  localparam logic [PH_W-1:0] PH_NONE = 2'd0;
  localparam logic [PH_W-1:0] PH_INIT = 2'd1;
  localparam logic [PH_W-1:0] PH_KSA  = 2'd2;
  localparam logic [PH_W-1:0] PH_PRGA = 2'd3;

  // One S-memory access request from a sub-block.
  typedef struct packed {
    logic [S_AW-1:0] addr;
    logic [S_DW-1:0] wrdata;
    logic            wren;
  } s_req_t;

  // Phase owning the S port in a given sequencer state.
  function automatic logic [PH_W-1:0] phase_of(input seq_state_t st);
    logic [PH_W-1:0] ph;
    case (st)
      ST_INIT, WT_INIT: ph = PH_INIT;
      ST_KSA,  WT_KSA:  ph = PH_KSA;
      ST_PRGA, WT_PRGA: ph = PH_PRGA;
      default:          ph = PH_NONE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/s_port_mux.sv
// Routes the active phase's S-memory request to the single memory port; idle phases are gated off.
module s_port_mux
  import arc4_pkg::*;
(
  input  logic [PH_W-1:0] i_phase,
  input  logic [S_AW-1:0] i_init_addr,
  input  logic [S_DW-1:0] i_init_wrdata,
  input  logic            i_init_wren,
  input  logic [S_AW-1:0] i_ksa_addr,
  input  logic [S_DW-1:0] i_ksa_wrdata,
  input  logic            i_ksa_wren,
  input  logic [S_AW-1:0] i_prga_addr,
  input  logic [S_DW-1:0] i_prga_wrdata,
  input  logic            i_prga_wren,
  output logic [S_AW-1:0] o_addr,
  output logic [S_DW-1:0] o_wrdata,
  output logic            o_wren
);

  s_req_t w_sel;

  always_comb begin
    w_sel = '0;
    case (i_phase)
      PH_INIT: w_sel = '{addr: i_init_addr, wrdata: i_init_wrdata, wren: i_init_wren};
      PH_KSA:  w_sel = '{addr: i_ksa_addr,  wrdata: i_ksa_wrdata,  wren: i_ksa_wren};
      PH_PRGA: w_sel = '{addr: i_prga_addr, wrdata: i_prga_wrdata, wren: i_prga_wren};
      default: w_sel = '0;
    endcase
  end

  assign o_addr   = w_sel.addr;
  assign o_wrdata = w_sel.wrdata;
  assign o_wren   = w_sel.wren;

endmodule

// File: rtl/arc4_seq.sv
// ARC4 decrypt-pass sequencer: key handshake, init->ksa->prga start/wait with a per-phase
// watchdog, and ownership of the shared S-memory write/address port.
module arc4_seq
  import arc4_pkg::*;
#(
  parameter int unsigned TIMEOUT = 200000
)
(
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_en,
  output logic             o_rdy,
  input  logic [KEY_W-1:0] i_key,
  output logic [KEY_W-1:0] o_key_out,
  output logic             o_err,
  output logic [PH_W-1:0]  o_phase,
  output logic             o_init_en,
  output logic             o_ksa_en,
  output logic             o_prga_en,
  input  logic             i_init_rdy,
  input  logic             i_ksa_rdy,
  input  logic             i_prga_rdy,
  input  logic [S_AW-1:0]  i_init_s_addr,
  input  logic [S_DW-1:0]  i_init_s_wrdata,
  input  logic             i_init_s_wren,
  input  logic [S_AW-1:0]  i_ksa_s_addr,
  input  logic [S_DW-1:0]  i_ksa_s_wrdata,
  input  logic             i_ksa_s_wren,
  input  logic [S_AW-1:0]  i_prga_s_addr,
  input  logic [S_DW-1:0]  i_prga_s_wrdata,
  input  logic             i_prga_s_wren,
  output logic [S_AW-1:0]  o_s_addr,
  output logic [S_DW-1:0]  o_s_wrdata,
  output logic             o_s_wren
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  seq_state_t       r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic             r_busy_seen, w_busy_nxt;
  logic [KEY_W-1:0] r_key_out, w_key_nxt;
  logic             r_err, w_err_nxt;
  logic             r_init_en, r_ksa_en, r_prga_en;
  logic             w_init_en_nxt, w_ksa_en_nxt, w_prga_en_nxt;
  logic             w_tmo;
  logic [PH_W-1:0]  w_phase;

  assign w_cnt_inc = r_cnt + CNT_W'(1);
  assign w_tmo     = (r_cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= S_RST;
      r_cnt       <= '0;
      r_busy_seen <= 1'b0;
      r_key_out   <= '0;
      r_err       <= 1'b0;
      r_init_en   <= 1'b0;
      r_ksa_en    <= 1'b0;
      r_prga_en   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_busy_seen <= w_busy_nxt;
      r_key_out   <= w_key_nxt;
      r_err       <= w_err_nxt;
      r_init_en   <= w_init_en_nxt;
      r_ksa_en    <= w_ksa_en_nxt;
      r_prga_en   <= w_prga_en_nxt;
    end
  end

  // A phase completes only after its sub-block has been seen busy, so a stale rdy=1 never counts.
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = '0;
    w_busy_nxt    = 1'b0;
    w_key_nxt     = r_key_out;
    w_err_nxt     = r_err;
    w_init_en_nxt = 1'b0;
    w_ksa_en_nxt  = 1'b0;
    w_prga_en_nxt = 1'b0;
    case (r_state)
      S_RST: w_state_nxt = IDLE;
      IDLE: begin
        if (i_en) begin
          w_state_nxt = ST_INIT;
          w_key_nxt   = i_key;
        end
      end
      ST_INIT: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_tmo) begin
          w_state_nxt = ERR;
        end else if (i_init_rdy) begin
          w_state_nxt   = WT_INIT;
          w_init_en_nxt = 1'b1;
        end
      end
      WT_INIT: begin
        w_cnt_nxt  = w_cnt_inc;
        w_busy_nxt = r_busy_seen | ~i_init_rdy;
        if (i_init_rdy && r_busy_seen) begin
          w_state_nxt = ST_KSA;
          w_cnt_nxt   = '0;
        end else if (w_tmo) begin
          w_state_nxt = ERR;
        end
      end
      ST_KSA: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_tmo) begin
          w_state_nxt = ERR;
        end else if (i_ksa_rdy) begin
          w_state_nxt  = WT_KSA;
          w_ksa_en_nxt = 1'b1;
        end
      end
      WT_KSA: begin
        w_cnt_nxt  = w_cnt_inc;
        w_busy_nxt = r_busy_seen | ~i_ksa_rdy;
        if (i_ksa_rdy && r_busy_seen) begin
          w_state_nxt = ST_PRGA;
          w_cnt_nxt   = '0;
        end else if (w_tmo) begin
          w_state_nxt = ERR;
        end
      end
      ST_PRGA: begin
        w_cnt_nxt = w_cnt_inc;
        if (w_tmo) begin
          w_state_nxt = ERR;
        end else if (i_prga_rdy) begin
          w_state_nxt   = WT_PRGA;
          w_prga_en_nxt = 1'b1;
        end
      end
      WT_PRGA: begin
        w_cnt_nxt  = w_cnt_inc;
        w_busy_nxt = r_busy_seen | ~i_prga_rdy;
        if (i_prga_rdy && r_busy_seen) begin
          w_state_nxt = IDLE;
        end else if (w_tmo) begin
          w_state_nxt = ERR;
        end
      end
      ERR:     w_state_nxt = ERR;
      default: w_state_nxt = S_RST;
    endcase
    if (w_state_nxt == ERR) begin
      w_err_nxt = 1'b1;
    end
  end

  assign w_phase   = phase_of(r_state);
  assign o_phase   = w_phase;
  assign o_rdy     = (r_state == IDLE);
  assign o_key_out = r_key_out;
  assign o_err     = r_err;
  assign o_init_en = r_init_en;
  assign o_ksa_en  = r_ksa_en;
  assign o_prga_en = r_prga_en;

  s_port_mux u_s_port_mux (
    .i_phase       (w_phase),
    .i_init_addr   (i_init_s_addr),
    .i_init_wrdata (i_init_s_wrdata),
    .i_init_wren   (i_init_s_wren),
    .i_ksa_addr    (i_ksa_s_addr),
    .i_ksa_wrdata  (i_ksa_s_wrdata),
    .i_ksa_wren    (i_ksa_s_wren),
    .i_prga_addr   (i_prga_s_addr),
    .i_prga_wrdata (i_prga_s_wrdata),
    .i_prga_wren   (i_prga_s_wren),
    .o_addr        (o_s_addr),
    .o_wrdata      (o_s_wrdata),
    .o_wren        (o_s_wren)
  );

endmodule

// File: tb/tb_arc4_seq.sv
// Directed bench for arc4_seq with simple init/ksa/prga handshake stubs (TIMEOUT=16).
module tb_arc4_seq;

  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst, en;
  logic [23:0] key;
  logic        rdy, err;
  logic [23:0] key_out;
  logic [1:0]  phase;
  logic        init_en, ksa_en, prga_en;
  logic        init_rdy, ksa_rdy, prga_rdy;
  logic [7:0]  init_addr, init_wrdata, ksa_addr, ksa_wrdata, prga_addr, prga_wrdata;
  logic        init_wren, ksa_wren, prga_wren;
  logic [7:0]  s_addr, s_wrdata;
  logic        s_wren;

  logic [2:0]  stub_rdy;
  logic [2:0]  hold;
  logic [2:0]  sub_en;
  int          busy_len[3];
  int          bcnt[3];
  bit          dly[3];
  int          en_cnt[3];
  int          en_time[3];
  int          cyc;
  int          n_tests, n_fail;

  always #5 clk = ~clk;

  assign sub_en   = {prga_en, ksa_en, init_en};
  assign init_rdy = stub_rdy[0] & ~hold[0];
  assign ksa_rdy  = stub_rdy[1] & ~hold[1];
  assign prga_rdy = stub_rdy[2] & ~hold[2];

  arc4_seq #(.TIMEOUT(TMO)) dut (
    .i_clk           (clk),
    .i_rst           (rst),
    .i_en            (en),
    .o_rdy           (rdy),
    .i_key           (key),
    .o_key_out       (key_out),
    .o_err           (err),
    .o_phase         (phase),
    .o_init_en       (init_en),
    .o_ksa_en        (ksa_en),
    .o_prga_en       (prga_en),
    .i_init_rdy      (init_rdy),
    .i_ksa_rdy       (ksa_rdy),
    .i_prga_rdy      (prga_rdy),
    .i_init_s_addr   (init_addr),
    .i_init_s_wrdata (init_wrdata),
    .i_init_s_wren   (init_wren),
    .i_ksa_s_addr    (ksa_addr),
    .i_ksa_s_wrdata  (ksa_wrdata),
    .i_ksa_s_wren    (ksa_wren),
    .i_prga_s_addr   (prga_addr),
    .i_prga_s_wrdata (prga_wrdata),
    .i_prga_s_wren   (prga_wren),
    .o_s_addr        (s_addr),
    .o_s_wrdata      (s_wrdata),
    .o_s_wren        (s_wren)
  );

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  // Sub-block stubs: rdy drops one cycle after en, returns busy_len cycles later.
  initial begin
    stub_rdy = 3'b111;
    for (int i = 0; i < 3; i++) begin
      dly[i] = 0; bcnt[i] = 0; en_cnt[i] = 0; en_time[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        if (rst === 1'b1) begin
          stub_rdy[i] = 1'b1; dly[i] = 0; bcnt[i] = 0;
        end else if (sub_en[i] === 1'b1) begin
          dly[i] = 1; en_cnt[i]++; en_time[i] = cyc;
        end else if (dly[i]) begin
          dly[i] = 0; stub_rdy[i] = 1'b0; bcnt[i] = busy_len[i];
        end else if (bcnt[i] > 0) begin
          bcnt[i]--;
          if (bcnt[i] == 0) stub_rdy[i] = 1'b1;
        end
      end
    end
  end

  task automatic start_run(input logic [23:0] k);
    key = k;
    en  = 1'b1;
    @(posedge clk); #1;
    en  = 1'b0;
  endtask

  task automatic wait_rdy(input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (rdy === 1'b1) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    init_wren = 1'b1; init_addr = 8'hFF;
    rst = 1'b1; en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (rdy !== 1'b0 || err !== 1'b0 || phase !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_status: rdy=%b err=%b phase=%0d, expected 0 0 0", rdy, err, phase);
    end
    n_tests++;
    if (key_out !== 24'h0) begin
      n_fail++; $display("FAIL reset_key_out: got %h expected 000000", key_out);
    end
    n_tests++;
    if ({init_en, ksa_en, prga_en} !== 3'b000) begin
      n_fail++; $display("FAIL reset_en: got %b expected 000", {init_en, ksa_en, prga_en});
    end
    n_tests++;
    if (s_wren !== 1'b0 || s_addr !== 8'h00) begin
      n_fail++; $display("FAIL reset_s_port: wren=%b addr=%h expected 0 00", s_wren, s_addr);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++; $display("FAIL reset_first_rdy: got %b expected 1", rdy);
    end
  endtask

  task automatic test_full_pass();
    int  c0[3];
    int  t0;
    bit  ok, ini_chk, ksa_chk, prg_chk;
    init_wren = 1'b1; init_addr = 8'hFF; init_wrdata = 8'h11;
    ksa_wren  = 1'b1; ksa_addr  = 8'h12; ksa_wrdata  = 8'h34;
    prga_wren = 1'b1; prga_addr = 8'hFF; prga_wrdata = 8'h33;
    for (int i = 0; i < 3; i++) c0[i] = en_cnt[i];
    t0 = cyc;
    ok = 0; ini_chk = 0; ksa_chk = 0; prg_chk = 0;
    n_tests++;
    if (s_wren !== 1'b0 || s_addr !== 8'h00) begin
      n_fail++; $display("FAIL idle_s_gate: wren=%b addr=%h expected 0 00", s_wren, s_addr);
    end
    start_run(24'h00033C);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (phase === 2'd1 && !ini_chk) begin
        ini_chk = 1; n_tests++;
        if (s_addr !== 8'hFF || s_wrdata !== 8'h11 || s_wren !== 1'b1) begin
          n_fail++;
          $display("FAIL init_s_mux: addr=%h data=%h wren=%b expected ff 11 1", s_addr, s_wrdata, s_wren);
        end
      end
      if (phase === 2'd2 && !ksa_chk) begin
        ksa_chk = 1; n_tests++;
        if (s_addr !== 8'h12 || s_wrdata !== 8'h34 || s_wren !== 1'b1) begin
          n_fail++;
          $display("FAIL ksa_s_mux: addr=%h data=%h wren=%b expected 12 34 1", s_addr, s_wrdata, s_wren);
        end
      end
      if (phase === 2'd3 && !prg_chk) begin
        prg_chk = 1; n_tests++;
        if (s_addr !== 8'hFF || s_wrdata !== 8'h33 || s_wren !== 1'b1) begin
          n_fail++;
          $display("FAIL prga_s_mux: addr=%h data=%h wren=%b expected ff 33 1", s_addr, s_wrdata, s_wren);
        end
      end
      if (rdy === 1'b1) begin
        ok = 1;
        break;
      end
    end
    n_tests++;
    if (!ok || !ini_chk || !ksa_chk || !prg_chk) begin
      n_fail++;
      $display("FAIL pass_complete: done=%0d phases_seen=%0d%0d%0d expected 1 111", ok, ini_chk, ksa_chk, prg_chk);
    end
    n_tests++;
    if (en_cnt[0] - c0[0] != 1 || en_cnt[1] - c0[1] != 1 || en_cnt[2] - c0[2] != 1) begin
      n_fail++;
      $display("FAIL en_pulses: init=%0d ksa=%0d prga=%0d expected 1 1 1",
               en_cnt[0] - c0[0], en_cnt[1] - c0[1], en_cnt[2] - c0[2]);
    end
    n_tests++;
    if (!(en_time[0] > t0 && en_time[0] < en_time[1] && en_time[1] < en_time[2])) begin
      n_fail++;
      $display("FAIL en_order: times %0d %0d %0d start %0d expected increasing", en_time[0], en_time[1], en_time[2], t0);
    end
    n_tests++;
    if (key_out !== 24'h00033C || err !== 1'b0) begin
      n_fail++; $display("FAIL pass_key_out: key=%h err=%b expected 00033c 0", key_out, err);
    end
    n_tests++;
    if (s_wren !== 1'b0 || phase !== 2'd0) begin
      n_fail++; $display("FAIL post_idle_gate: wren=%b phase=%0d expected 0 0", s_wren, phase);
    end
  endtask

  task automatic test_ignore_en();
    int c0;
    bit ok;
    c0 = en_cnt[0];
    start_run(24'h123456);
    repeat (5) @(posedge clk);
    #1;
    key = 24'hAAAAAA; en = 1'b1;
    @(posedge clk); #1;
    en = 1'b0;
    wait_rdy(200, ok);
    n_tests++;
    if (!ok || key_out !== 24'h123456) begin
      n_fail++; $display("FAIL busy_en_key: done=%0d key=%h expected 1 123456", ok, key_out);
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (en_cnt[0] - c0 != 1 || rdy !== 1'b1 || phase !== 2'd0) begin
      n_fail++;
      $display("FAIL busy_en_queued: init_pulses=%0d rdy=%b phase=%0d expected 1 1 0", en_cnt[0] - c0, rdy, phase);
    end
  endtask

  task automatic test_init_hold();
    int c0;
    bit ok, quiet;
    hold[0] = 1'b1; busy_len[0] = 4;
    c0 = en_cnt[0];
    quiet = 1;
    start_run(24'h000001);
    repeat (5) begin
      @(posedge clk); #1;
      if (init_en !== 1'b0 || phase !== 2'd1) quiet = 0;
    end
    n_tests++;
    if (!quiet) begin
      n_fail++; $display("FAIL init_hold_quiet: init_en=%b phase=%0d expected 0 1", init_en, phase);
    end
    hold[0] = 1'b0;
    wait_rdy(200, ok);
    n_tests++;
    if (!ok || en_cnt[0] - c0 != 1) begin
      n_fail++; $display("FAIL init_hold_pulse: done=%0d pulses=%0d expected 1 1", ok, en_cnt[0] - c0);
    end
    busy_len[0] = 10;
  endtask

  task automatic test_rst_mid_prga();
    bit ok;
    ok = 0;
    start_run(24'h0000AB);
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (prga_en === 1'b1) begin
        ok = 1;
        break;
      end
    end
    n_tests++;
    if (!ok || phase !== 2'd3 || s_wren !== 1'b1) begin
      n_fail++; $display("FAIL prga_reached: seen=%0d phase=%0d wren=%b expected 1 3 1", ok, phase, s_wren);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (prga_en !== 1'b0 || s_wren !== 1'b0 || phase !== 2'd0 || rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_abort: prga_en=%b wren=%b phase=%0d rdy=%b expected 0 0 0 0", prga_en, s_wren, phase, rdy);
    end
    rst = 1'b0;
    n_tests++;
    if (rdy !== 1'b0) begin
      n_fail++; $display("FAIL rst_drop_rdy: got %b expected 0", rdy);
    end
    @(posedge clk); #1;
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++; $display("FAIL rst_second_rdy: got %b expected 1", rdy);
    end
  endtask

  task automatic test_timeout();
    int n2;
    bit done;
    n2 = 0; done = 0;
    busy_len[1] = 1000;
    start_run(24'h0000CD);
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #1;
      if (phase === 2'd2) n2++;
      else if (n2 > 0) begin
        done = 1;
        break;
      end
    end
    n_tests++;
    if (!done || n2 != 16) begin
      n_fail++; $display("FAIL ksa_timeout_len: left=%0d cycles=%0d expected 1 16", done, n2);
    end
    n_tests++;
    if (err !== 1'b1 || rdy !== 1'b0 || s_wren !== 1'b0 || phase !== 2'd0) begin
      n_fail++;
      $display("FAIL err_state: err=%b rdy=%b wren=%b phase=%0d expected 1 0 0 0", err, rdy, s_wren, phase);
    end
    repeat (5) @(posedge clk);
    #1;
    n_tests++;
    if (err !== 1'b1 || rdy !== 1'b0 || {init_en, ksa_en, prga_en} !== 3'b000) begin
      n_fail++;
      $display("FAIL err_sticky: err=%b rdy=%b en=%b expected 1 0 000", err, rdy, {init_en, ksa_en, prga_en});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++; $display("FAIL err_clear: got %b expected 0", err);
    end
    @(posedge clk); #1;
    n_tests++;
    if (rdy !== 1'b1) begin
      n_fail++; $display("FAIL err_recover_rdy: got %b expected 1", rdy);
    end
    busy_len[1] = 10;
  endtask

  initial begin
    n_tests = 0; n_fail = 0;
    rst = 1'b1; en = 1'b0; key = '0; hold = 3'b000;
    busy_len[0] = 10; busy_len[1] = 10; busy_len[2] = 10;
    init_addr = '0; init_wrdata = '0; init_wren = 1'b0;
    ksa_addr  = '0; ksa_wrdata  = '0; ksa_wren  = 1'b0;
    prga_addr = '0; prga_wrdata = '0; prga_wren = 1'b0;
    test_reset();
    test_full_pass();
    test_ignore_en();
    test_init_hold();
    test_rst_mid_prga();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
